// File: rtl/sap_pkg.sv
// Shared constants and FSM state encoding for the SAP RAM sequencing controller.
package sap_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned PORT0 = 0;
    localparam int unsigned PORT1 = 1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StWpulse = 3'd2,
        StRwait  = 3'd3,
        StHold   = 3'd4,
        StDone   = 3'd5
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the port that did not win last time wins a tie.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Resets to port 1 so that port 0 takes the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_adv && (|i_req)) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/sap_ram_ctrl.sv
// Shares one SN74189 16x4 RAM between two requesters, sequencing select, write
// pulse and read capture with safe setup/hold; read data is returned in true polarity.
module sap_ram_ctrl
    import sap_pkg::*;
#(
    parameter int unsigned WR_PULSE = 1,
    parameter int unsigned RD_WAIT  = 1
) (
    input  logic              i_CLK,
    input  logic              i_CLR_bar,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ram_A,
    output logic [DATA_W-1:0] o_ram_DI,
    output logic              o_ram_S_bar,
    output logic              o_ram_W_bar,
    input  logic [DATA_W-1:0] i_ram_DO
);

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_port;
    logic                r_we;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_busy;
    logic                r_ram_S_bar;
    logic                r_ram_W_bar;
    logic [ADDR_W-1:0]   r_ram_A;
    logic [DATA_W-1:0]   r_ram_DI;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          w_grant;
    logic                w_idle;

    assign w_idle = (r_state == StIdle);

    rr_arb2 u_arb (
        .i_clk   (i_CLK),
        .i_rst_n (i_CLR_bar),
        .i_req   ({i_req1, i_req0}),
        .i_adv   (w_idle),
        .o_grant (w_grant)
    );

    always_ff @(posedge i_CLK) begin
        if (!i_CLR_bar) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_busy      <= 1'b0;
            r_ram_S_bar <= 1'b1;
            r_ram_W_bar <= 1'b1;
            r_ram_A     <= '0;
            r_ram_DI    <= '0;
            r_rdata     <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (|w_grant) begin
                        r_port      <= w_grant[1];
                        r_we        <= w_grant[1] ? i_we1    : i_we0;
                        r_ram_A     <= w_grant[1] ? i_addr1  : i_addr0;
                        r_ram_DI    <= w_grant[1] ? i_wdata1 : i_wdata0;
                        r_ram_S_bar <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= StSetup;
                    end
                end
                StSetup: begin
                    if (r_we) begin
                        r_ram_W_bar <= 1'b0;
                        r_cnt       <= CNT_W'(WR_PULSE - 1);
                        r_state     <= StWpulse;
                    end else begin
                        r_cnt       <= CNT_W'(RD_WAIT - 1);
                        r_state     <= StRwait;
                    end
                end
                StWpulse: begin
                    if (r_cnt == '0) begin
                        r_ram_W_bar <= 1'b1;
                        r_state     <= StHold;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StRwait, StHold: begin
                    // HOLD always finishes; RWAIT finishes when its count expires.
                    if ((r_state == StHold) || (r_cnt == '0)) begin
                        if (r_state == StRwait) begin
                            r_rdata <= ~i_ram_DO;
                        end
                        r_ram_S_bar <= 1'b1;
                        r_ack0      <= ~r_port;
                        r_ack1      <= r_port;
                        r_state     <= StDone;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_ack0      = r_ack0;
    assign o_ack1      = r_ack1;
    assign o_rdata     = r_rdata;
    assign o_busy      = r_busy;
    assign o_ram_A     = r_ram_A;
    assign o_ram_DI    = r_ram_DI;
    assign o_ram_S_bar = r_ram_S_bar;
    assign o_ram_W_bar = r_ram_W_bar;

endmodule

// File: tb/tb_sap_ram_ctrl.sv
// Randomized bench for sap_ram_ctrl against a transaction-level RAM/arbitration model.
module tb_sap_ram_ctrl;

    localparam int unsigned WR = 3;
    localparam int unsigned RD = 2;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy, s_bar, w_bar;
    logic [3:0] rdata, ram_a, ram_di, ram_do;

    always #5 clk = ~clk;

    sap_ram_ctrl #(
        .WR_PULSE (WR),
        .RD_WAIT  (RD)
    ) u_dut (
        .i_CLK       (clk),
        .i_CLR_bar   (clr_n),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_we0       (we0),
        .i_we1       (we1),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_wdata0    (wdata0),
        .i_wdata1    (wdata1),
        .o_ack0      (ack0),
        .o_ack1      (ack1),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .o_ram_A     (ram_a),
        .o_ram_DI    (ram_di),
        .o_ram_S_bar (s_bar),
        .o_ram_W_bar (w_bar),
        .i_ram_DO    (ram_do)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // SN74189 model: stores on select+write, outputs complemented data.
    logic [3:0] mem [16] = '{default: 4'h0};
    always @(posedge clk) if (s_bar === 1'b0 && w_bar === 1'b0) mem[ram_a] <= ram_di;
    assign ram_do = ~mem[ram_a];

    bit         mon_en = 1'b0;
    logic       prev_wlow = 1'b0;
    logic [7:0] prev_ad = '0;
    int         n_ack0 = 0;
    int         n_ack1 = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("we_without_select", 32'(s_bar & ~w_bar), 32'(0));
            if (prev_wlow && !w_bar) check_eq("ad_stable_wlow", 32'({ram_a, ram_di}), 32'(prev_ad));
            if (ack0) n_ack0++;
            if (ack1) n_ack1++;
        end
        prev_wlow = ~w_bar;
        prev_ad   = {ram_a, ram_di};
    end

    logic [3:0] ref_mem [16];
    bit         ref_valid [16];
    logic [3:0] ref_rdata;
    int         ref_last;

    function automatic int lat(input bit we);
        return we ? int'(3 + WR) : int'(2 + RD);
    endfunction

    task automatic drive(input int port, input bit r, input bit we, input logic [3:0] a,
                         input logic [3:0] d);
        if (port == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic model_done(input int port, input bit we, input logic [3:0] a,
                              input logic [3:0] d);
        if (we) begin
            ref_mem[a]   = d;
            ref_valid[a] = 1'b1;
        end else begin
            ref_rdata = ref_mem[a];
        end
        ref_last = port;
        check_eq("rdata", 32'(rdata), 32'(ref_rdata));
    endtask

    task automatic do_txn(input int port, input bit we, input logic [3:0] a,
                          input logic [3:0] d, input bit mutate);
        int n = 0;
        int sl = 0;
        int wl = 0;
        drive(port, 1'b1, we, a, d);
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (mutate) drive(port, 1'b1, we, a + 4'd4, ~d);
            check_eq("ram_ad_latched", 32'({ram_a, ram_di}), 32'({a, d}));
            if (ack0 || ack1) break;
            if (!s_bar) sl++;
            if (!w_bar) wl++;
        end
        check_eq("latency", 32'(n), 32'(lat(we)));
        check_eq("ack_port", 32'({ack1, ack0}), (port == 1) ? 32'd2 : 32'd1);
        check_eq("sbar_low_cycles", 32'(sl), we ? 32'(2 + WR) : 32'(1 + RD));
        check_eq("wbar_low_cycles", 32'(wl), we ? 32'(WR) : 32'(0));
        check_eq("busy_in_done", 32'(busy), 32'(1));
        model_done(port, we, a, d);
        drive(port, 1'b0, we, a, d);
        @(posedge clk); #1;
        check_eq("idle_after_done", 32'({busy, ack1, ack0}), 32'(0));
    endtask

    task automatic contend(input int ntx, input bit w0, input logic [3:0] a0, input logic [3:0] d0,
                           input bit w1, input logic [3:0] a1, input logic [3:0] d1);
        int  p;
        int  n;
        bit  w;
        logic [3:0] a, d;
        p = (ref_last == 1) ? 0 : 1;
        drive(0, 1'b1, w0, a0, d0);
        drive(1, 1'b1, w1, a1, d1);
        for (int k = 0; k < ntx; k++) begin
            w = (p == 1) ? w1 : w0;
            a = (p == 1) ? a1 : a0;
            d = (p == 1) ? d1 : d0;
            n = 0;
            while (n < 40) begin
                @(posedge clk); #1; n++;
                if (ack0 || ack1) break;
            end
            check_eq("rr_latency", 32'(n), 32'(lat(w)));
            check_eq("rr_order", 32'({ack1, ack0}), (p == 1) ? 32'd2 : 32'd1);
            model_done(p, w, a, d);
            if (k == ntx - 1) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(posedge clk); #1;
            check_eq("rr_idle_gap", 32'({busy, ack1, ack0}), 32'(0));
            p = 1 - p;
        end
    endtask

    initial begin
        if (WR < 1 || WR > 15 || RD < 1 || RD > 15) begin
            $display("FAIL param_range: WR_PULSE=%0d RD_WAIT=%0d, required 1..15", WR, RD);
            $fatal(1);
        end
    end

    initial begin
        int         a0, b0;
        int         port;
        bit         we, wx;
        logic [3:0] a, d, ax, dx;

        clr_n = 1'b0;
        drive(1, 1'b0, 1'b0, 4'h0, 4'h0);
        drive(0, 1'b1, 1'b1, 4'h3, 4'hF);
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_mem[i]   = 4'h0;
        end
        ref_rdata = 4'h0;
        ref_last  = 1;

        // Reset held with a pending request.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_eq("reset_state", 32'({ack1, ack0, busy, s_bar, w_bar, rdata, ram_a, ram_di}),
                     32'h3000);
        end
        req0  = 1'b0;
        clr_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_after_reset", 32'({busy, s_bar, w_bar}), 32'b011);

        do_txn(0, 1'b1, 4'h3, 4'hA, 1'b0);
        do_txn(0, 1'b0, 4'h3, 4'h0, 1'b0);

        a0 = n_ack0;
        b0 = n_ack1;
        for (int k = 0; k < 16; k++) do_txn(1, 1'b1, 4'(k), 4'((k + 5) % 16), 1'b0);
        for (int k = 0; k < 16; k++) do_txn(0, 1'b0, 4'(k), 4'($urandom), 1'b0);
        check_eq("fill_ack1_count", 32'(n_ack1 - b0), 32'd16);
        check_eq("fill_ack0_count", 32'(n_ack0 - a0), 32'd16);

        // Address/data changed mid-write must not leak into the transaction.
        do_txn(0, 1'b1, 4'h5, 4'hC, 1'b1);
        do_txn(0, 1'b0, 4'h9, 4'h0, 1'b0);
        do_txn(0, 1'b0, 4'h5, 4'h0, 1'b0);

        contend(6, 1'b0, 4'h3, 4'h0, 1'b0, 4'h5, 4'h0);

        repeat (40) begin
            port = int'($urandom_range(0, 1));
            a    = 4'($urandom);
            d    = 4'($urandom);
            we   = ($urandom_range(0, 1) == 1) || !ref_valid[a];
            do_txn(port, we, a, d, 1'($urandom_range(0, 1)));
        end

        repeat (3) begin
            a  = 4'($urandom);
            d  = 4'($urandom);
            ax = 4'($urandom);
            dx = 4'($urandom);
            we = ($urandom_range(0, 1) == 1) || !ref_valid[a];
            wx = ($urandom_range(0, 1) == 1) || !ref_valid[ax];
            contend(6, we, a, d, wx, ax, dx);
        end

        // Reset in the second write-pulse cycle: transaction dropped, no ack.
        drive(0, 1'b1, 1'b1, 4'h7, 4'h5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check_eq("in_wpulse_before_reset", 32'({s_bar, w_bar}), 32'b00);
        clr_n = 1'b0;
        req0  = 1'b0;
        @(posedge clk); #1;
        check_eq("reset_mid_write", 32'({ack1, ack0, busy, s_bar, w_bar, rdata, ram_a, ram_di}),
                 32'h3000);
        clr_n        = 1'b1;
        ref_valid[7] = 1'b0;
        ref_rdata    = 4'h0;
        ref_last     = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("no_ack_after_abort", 32'({busy, ack1, ack0}), 32'(0));
        end

        contend(4, 1'b1, 4'h7, 4'h9, 1'b0, 4'h3, 4'h0);
        do_txn(1, 1'b0, 4'h7, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
